// File: rtl/boot_loader_if.sv
// boot_loader_if
//   Handshake and memory-write bundle between a byte source, the boot loader
//   and the instruction/data memory write port.
//
//   rx_data  [7:0]  byte offered by the source
//   rx_valid        rx_data is valid
//   rx_ready        loader accepts a byte this cycle
//   mem_addr [31:0] memory byte address
//   mem_data [31:0] memory write data
//   mem_wr          one-cycle write strobe per word
//
//   slave  : the loader (consumes bytes, drives the memory port)
//   master : the environment (byte source and memory side)
interface boot_loader_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic        mem_wr;

    modport master (
        output rx_data, rx_valid,
        input  rx_ready, mem_addr, mem_data, mem_wr
    );

    modport slave (
        input  rx_data, rx_valid,
        output rx_ready, mem_addr, mem_data, mem_wr
    );
endinterface

// File: rtl/boot_loader.sv
// boot_loader
//   Program loader in front of the multicycle CPU. Receives a byte stream
//   (16-bit word count N high byte first, then 4*N big-endian data bytes,
//   then an optional checksum byte), writes each assembled word to memory
//   at BASE_ADDR + 4*index, and holds the CPU in reset until the whole
//   image is written.
//
//   Parameters:
//     BASE_ADDR     byte address of the first word
//     MAX_WORDS     largest accepted word count
//   Ports:
//     clk           system clock, rising edge
//     reset         asynchronous, active-low reset
//     bus           boot_loader_if.slave (rx handshake + memory write port)
//     cpu_reset     active-high reset to the CPU, low only once loaded
//     done          image loaded successfully
//     error         load aborted (count too large or checksum mismatch)
//     words_loaded  words written so far
//
//   Compile option: define BOOT_CHECKSUM_EN to require a trailing checksum
//   byte making the 8-bit sum of every stream byte equal to zero.
module boot_loader #(
    parameter logic [31:0] BASE_ADDR = 32'd0,
    parameter int unsigned MAX_WORDS = 64
) (
    input  logic          clk,
    input  logic          reset,
    boot_loader_if.slave  bus,
    output logic          cpu_reset,
    output logic          done,
    output logic          error,
    output logic [15:0]   words_loaded
);

    typedef enum logic [2:0] {
        HDR_HI,
        HDR_LO,
        DATA,
        WRITE,
`ifdef BOOT_CHECKSUM_EN
        CHK,
`endif
        DONE,
        ERR
    } state_t;

    localparam logic [15:0] MAX_N = 16'(MAX_WORDS);

    // State entered once the final word is written (or N = 0).
`ifdef BOOT_CHECKSUM_EN
    localparam state_t FIN_STATE = CHK;
`else
    localparam state_t FIN_STATE = DONE;
`endif

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_count;
    logic [23:0] r_shift;
    logic [31:0] r_word;
    logic [1:0]  r_idx;
    logic [15:0] r_words;
    logic        w_ready;
    logic        w_accept;
    logic [15:0] w_hdr_n;
    logic        w_last_word;
`ifdef BOOT_CHECKSUM_EN
    logic [7:0]  r_sum;
    logic [7:0]  w_sum_next;
`endif

    assign w_accept    = bus.rx_valid && w_ready;
    assign w_hdr_n     = {r_count[15:8], bus.rx_data};
    assign w_last_word = (r_words + 16'd1) == r_count;
`ifdef BOOT_CHECKSUM_EN
    assign w_sum_next  = r_sum + bus.rx_data;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= HDR_HI;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        w_ready      = 1'b0;
        bus.rx_ready = 1'b0;
        bus.mem_wr   = 1'b0;
        bus.mem_addr = BASE_ADDR + {14'd0, r_words, 2'b00};
        bus.mem_data = r_word;
        done         = 1'b0;
        error        = 1'b0;
        cpu_reset    = 1'b1;
        words_loaded = r_words;

        case (r_state)
            HDR_HI: begin
                w_ready = reset;
                if (w_accept) w_next = HDR_LO;
            end
            HDR_LO: begin
                w_ready = reset;
                if (w_accept) begin
                    if (w_hdr_n > MAX_N)     w_next = ERR;
                    else if (w_hdr_n == '0)  w_next = FIN_STATE;
                    else                     w_next = DATA;
                end
            end
            DATA: begin
                w_ready = reset;
                if (w_accept && r_idx == 2'd3) w_next = WRITE;
            end
            WRITE: begin
                bus.mem_wr = 1'b1;
                w_next     = w_last_word ? FIN_STATE : DATA;
            end
`ifdef BOOT_CHECKSUM_EN
            CHK: begin
                w_ready = reset;
                if (w_accept) w_next = (w_sum_next == '0) ? DONE : ERR;
            end
`endif
            DONE: begin
                done      = 1'b1;
                cpu_reset = 1'b0;
            end
            ERR: begin
                error = 1'b1;
            end
            default: w_next = ERR;
        endcase

        bus.rx_ready = w_ready;
    end

    // First three bytes of a word collect in r_shift; the fourth completes
    // r_word, so mem_data keeps showing the previous word while assembling.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
            r_shift <= '0;
            r_word  <= '0;
            r_idx   <= '0;
            r_words <= '0;
`ifdef BOOT_CHECKSUM_EN
            r_sum   <= '0;
`endif
        end else begin
            if (w_accept) begin
`ifdef BOOT_CHECKSUM_EN
                r_sum <= w_sum_next;
`endif
                case (r_state)
                    HDR_HI: r_count[15:8] <= bus.rx_data;
                    HDR_LO: r_count[7:0]  <= bus.rx_data;
                    DATA: begin
                        r_idx <= r_idx + 2'd1;
                        if (r_idx == 2'd3) begin
                            r_word <= {r_shift, bus.rx_data};
                        end else begin
                            r_shift <= {r_shift[15:0], bus.rx_data};
                        end
                    end
                    default: ;
                endcase
            end
            if (r_state == WRITE) begin
                r_words <= r_words + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_boot_loader.sv
// tb_boot_loader
//   Randomised bench for boot_loader. Streams are built as byte queues; the
//   expected memory writes and final status are derived from the stream
//   format rules (header count, big-endian words, zero-sum checksum when
//   BOOT_CHECKSUM_EN is defined) and compared with what the loader does.
module tb_boot_loader;

    localparam logic [31:0] TB_BASE = 32'h0000_0000;
    localparam int unsigned TB_MAX  = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_reset;
    logic        done;
    logic        error;
    logic [15:0] words_loaded;

    boot_loader_if bus();

    boot_loader #(
        .BASE_ADDR (TB_BASE),
        .MAX_WORDS (TB_MAX)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .cpu_reset    (cpu_reset),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_errs   = 0;

    logic [7:0]  stream[$];
    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Capture every memory write; the loader must never take a byte then.
    always @(negedge clk) begin
        if (bus.mem_wr === 1'b1) begin
            wr_addr.push_back(bus.mem_addr);
            wr_data.push_back(bus.mem_data);
            check_val("ready_during_write", {31'd0, bus.rx_ready}, 32'd0);
        end
    end

    task automatic check_reset_vals(input string tag);
        check_val({tag, ":rx_ready"},     {31'd0, bus.rx_ready}, 32'd0);
        check_val({tag, ":mem_wr"},       {31'd0, bus.mem_wr},   32'd0);
        check_val({tag, ":done"},         {31'd0, done},         32'd0);
        check_val({tag, ":error"},        {31'd0, error},        32'd0);
        check_val({tag, ":cpu_reset"},    {31'd0, cpu_reset},    32'd1);
        check_val({tag, ":mem_addr"},     bus.mem_addr,          TB_BASE);
        check_val({tag, ":mem_data"},     bus.mem_data,          32'd0);
        check_val({tag, ":words_loaded"}, {16'd0, words_loaded}, 32'd0);
    endtask

    task automatic do_reset();
        reset        = 1'b0;
        bus.rx_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Offer bytes with rx_valid randomly asserted (vprob percent per cycle);
    // a byte advances only when the loader took it at the clock edge.
    task automatic send_stream(input int unsigned nbytes, input int unsigned vprob);
        int unsigned i   = 0;
        int unsigned cyc = 0;
        logic        acc;
        while (i < nbytes && cyc < 3000) begin
            bus.rx_valid = ($urandom_range(99) < vprob);
            bus.rx_data  = bus.rx_valid ? stream[i] : 8'($urandom);
            @(negedge clk);
            acc = bus.rx_valid && bus.rx_ready;
            @(posedge clk);
            #1;
            if (acc) i++;
            cyc++;
        end
        bus.rx_valid = 1'b0;
        check_val("stream_accepted", i, nbytes);
    endtask

    task automatic build_stream(input int unsigned n, input bit corrupt);
        logic [7:0] s;
        stream.delete();
        stream.push_back(n[15:8]);
        stream.push_back(n[7:0]);
        if (n <= TB_MAX) begin
            for (int i = 0; i < 4 * n; i++) stream.push_back(8'($urandom));
`ifdef BOOT_CHECKSUM_EN
            s = '0;
            foreach (stream[i]) s = s + stream[i];
            stream.push_back((8'h00 - s) + (corrupt ? 8'h01 : 8'h00));
`endif
        end
    endtask

    task automatic build_plan(input bit corrupt);
        logic [7:0] s;
        stream = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05,
                   8'hAC, 8'h08, 8'h00, 8'h10};
`ifdef BOOT_CHECKSUM_EN
        s = '0;
        foreach (stream[i]) s = s + stream[i];
        // checksum byte chosen so the 8-bit sum of all bytes is zero
        stream.push_back((8'h00 - s) + (corrupt ? 8'h01 : 8'h00));
`endif
    endtask

    task automatic run_case(input string name, input int unsigned vprob, input bit with_reset);
        int unsigned n;
        bit          hdr_err;
        bit          exp_ok;
        int unsigned nsend;
        int unsigned exp_lat;
        int unsigned k;
        int unsigned exp_writes;
        logic [7:0]  s;
        logic [31:0] exp_word;

        n       = {16'd0, stream[0], stream[1]};
        hdr_err = n > TB_MAX;
        nsend   = hdr_err ? 2 : stream.size();
        if (with_reset) do_reset();
        wr_addr.delete();
        wr_data.delete();
        send_stream(nsend, vprob);

        exp_ok = !hdr_err;
`ifdef BOOT_CHECKSUM_EN
        if (!hdr_err) begin
            s = '0;
            for (int i = 0; i < 2 + 4 * n + 1; i++) s = s + stream[i];
            exp_ok = (s == 8'h00);
        end
        exp_lat = 1;
`else
        exp_lat = (hdr_err || n == 0) ? 1 : 2;
`endif

        k = 0;
        while (k < 20) begin
            @(negedge clk);
            k++;
            if (done || error) break;
        end
        check_val({name, ":latency"}, k, exp_lat);
        repeat (2) @(negedge clk);

        exp_writes = hdr_err ? 0 : n;
        check_val({name, ":write_count"}, wr_data.size(), exp_writes);
        for (int i = 0; i < wr_data.size() && i < exp_writes; i++) begin
            exp_word = {stream[2 + 4 * i], stream[3 + 4 * i],
                        stream[4 + 4 * i], stream[5 + 4 * i]};
            check_val({name, ":addr"}, wr_addr[i], TB_BASE + 32'(4 * i));
            check_val({name, ":data"}, wr_data[i], exp_word);
        end
        check_val({name, ":done"},         {31'd0, done},         {31'd0, exp_ok});
        check_val({name, ":error"},        {31'd0, error},        {31'd0, !exp_ok});
        check_val({name, ":cpu_reset"},    {31'd0, cpu_reset},    {31'd0, !exp_ok});
        check_val({name, ":words_loaded"}, {16'd0, words_loaded}, exp_writes);
        check_val({name, ":rx_ready_end"}, {31'd0, bus.rx_ready}, 32'd0);
        check_val({name, ":mem_wr_end"},   {31'd0, bus.mem_wr},   32'd0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int unsigned n;
        int unsigned r;
        reset        = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        #1;
        check_reset_vals("por");

        build_plan(1'b0);
        run_case("plan_ok", 100, 1'b1);

`ifdef BOOT_CHECKSUM_EN
        build_plan(1'b1);
        run_case("plan_badsum", 100, 1'b1);
`endif

        stream = '{8'h00, 8'h41};
        run_case("hdr_over", 100, 1'b1);

        build_stream(0, 1'b0);
        run_case("hdr_zero", 100, 1'b1);

        build_plan(1'b0);
        run_case("plan_gappy", 45, 1'b1);

        build_stream(TB_MAX, 1'b0);
        run_case("max_words", 80, 1'b1);

        // Abort mid-load after six data bytes, then load a one-word image.
        do_reset();
        build_plan(1'b0);
        wr_data.delete();
        wr_addr.delete();
        send_stream(8, 100);
        check_val("midrst:partial_writes", wr_data.size(), 1);
        reset = 1'b0;
        #1;
        check_reset_vals("midrst");
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        stream = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78};
`ifdef BOOT_CHECKSUM_EN
        stream.push_back(8'h00 - (8'h01 + 8'h12 + 8'h34 + 8'h56 + 8'h78));
`endif
        run_case("after_rst", 70, 1'b0);

        for (int t = 0; t < 12; t++) begin
            r = $urandom_range(9);
            if (r == 0) n = $urandom_range(65535, TB_MAX + 1);
            else        n = $urandom_range(6, 0);
            build_stream(n, ($urandom_range(3) == 0));
            run_case("rand", $urandom_range(100, 30), 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
